// File: rtl/pwm_timer_multi_pkg.sv
// pwm_timer_multi_pkg: shared state encoding and default widths for the multi-channel PWM timer
package pwm_timer_multi_pkg;
  localparam int DEF_WIDTH    = 24;
  localparam int DEF_CHANNELS = 4;
  localparam int DEF_PS_WIDTH = 8;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
endpackage

// File: rtl/pwm_compare_ch.sv
// pwm_compare_ch: one compare channel with its shadowed compare value and registered flag
module pwm_compare_ch #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             run,
  input  logic [WIDTH-1:0] cnt_d,
  input  logic [WIDTH-1:0] cmp_in,
  output logic             flag
);
  logic [WIDTH-1:0] cmp_q, cmp_d;
  logic             flag_q, flag_d;
  always_comb begin
    cmp_d  = load ? cmp_in : cmp_q;
    flag_d = run && (cnt_d < cmp_d);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmp_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cmp_q  <= cmp_d;
      flag_q <= flag_d;
    end
  end
  assign flag = flag_q;
endmodule

// File: rtl/pwm_timer_multi.sv
// pwm_timer_multi: prescaled shared up-counter with N shadowed compare channels,
// continuous or one-shot, all shadows reloading at the period boundary.
module pwm_timer_multi
  import pwm_timer_multi_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int PS_WIDTH = DEF_PS_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      one_shot,
  input  logic [PS_WIDTH-1:0]       tmr_prescale,
  input  logic [WIDTH-1:0]          tmr_period,
  input  logic [CHANNELS*WIDTH-1:0] tmr_compare,
  output logic [WIDTH-1:0]          tmr_count,
  output logic [CHANNELS-1:0]       flag,
  output logic                      ovf,
  output logic                      busy
);
  state_t              state_q, state_d;
  logic [WIDTH-1:0]    cnt_q, cnt_d, per_q, per_d;
  logic [PS_WIDTH-1:0] ps_q, ps_d, ps_sh_q, ps_sh_d;
  logic                mode_q, mode_d, ovf_q, ovf_d;
  logic                tick, term, load;
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    ps_d    = '0;
    ovf_d   = 1'b0;
    load    = 1'b0;
    tick    = ps_q == ps_sh_q;
    term    = tick && (cnt_q == per_q);
    unique case (state_q)
      ST_IDLE: if (en) begin
        state_d = ST_RUN;
        load    = 1'b1;
      end
      ST_RUN: if (!en) state_d = ST_IDLE;
      else begin
        ps_d  = tick ? '0 : ps_q + PS_WIDTH'(1);
        cnt_d = !tick ? cnt_q : term ? '0 : cnt_q + WIDTH'(1);
        ovf_d = term;
        load  = term;
        if (term && mode_q) state_d = ST_DONE;
      end
      ST_DONE: if (!en) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    per_d   = load ? tmr_period : per_q;
    ps_sh_d = load ? tmr_prescale : ps_sh_q;
    // Mode is latched only when a run starts, so a pass never changes mode mid-flight
    mode_d  = (state_q == ST_IDLE && en) ? one_shot : mode_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ps_q    <= '0;
      per_q   <= '0;
      ps_sh_q <= '0;
      mode_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ps_q    <= ps_d;
      per_q   <= per_d;
      ps_sh_q <= ps_sh_d;
      mode_q  <= mode_d;
      ovf_q   <= ovf_d;
    end
  end
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pwm_compare_ch #(.WIDTH(WIDTH)) u_ch (
      .clk    (clk),
      .rst    (rst),
      .load   (load),
      .run    (state_d == ST_RUN),
      .cnt_d  (cnt_d),
      .cmp_in (tmr_compare[i*WIDTH +: WIDTH]),
      .flag   (flag[i])
    );
  end
  assign tmr_count = cnt_q;
  assign ovf       = ovf_q;
  assign busy      = state_q == ST_RUN;
endmodule

// File: tb/tb_pwm_timer_multi.sv
// tb_pwm_timer_multi: scoreboard bench; expected outputs are derived arithmetically from the timing rules
module tb_pwm_timer_multi;
  localparam int W = 24, C = 4, PW = 8;
  logic           clk = 0, rst = 0, en = 0, one_shot = 0;
  logic [PW-1:0]  ps = '0;
  logic [W-1:0]   per = '0;
  logic [C*W-1:0] cmp = '0;
  logic [W-1:0]   tmr_count;
  logic [C-1:0]   flag;
  logic           ovf, busy;
  typedef struct packed {logic [W-1:0] cnt; logic [C-1:0] flag; logic ovf; logic busy;} exp_t;
  exp_t sb[$];
  exp_t got, e;
  int n_chk = 0, n_fail = 0;

  pwm_timer_multi #(.WIDTH(W), .CHANNELS(C), .PS_WIDTH(PW)) dut (
    .clk(clk), .rst(rst), .en(en), .one_shot(one_shot), .tmr_prescale(ps),
    .tmr_period(per), .tmr_compare(cmp), .tmr_count(tmr_count), .flag(flag),
    .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, failures=%0d required 0", n_fail);
    $fatal(1, "watchdog");
  end

  // Sample j counts negedges after the IDLE->RUN edge; j=0 is right after that edge.
  function automatic exp_t model(int j, int ps_v, int p_v, logic [C*W-1:0] c_v);
    exp_t r;
    r.cnt  = W'((j / (ps_v + 1)) % (p_v + 1));
    r.ovf  = (j > 0) && (j % ((ps_v + 1) * (p_v + 1)) == 0);
    r.busy = 1'b1;
    for (int i = 0; i < C; i++) r.flag[i] = r.cnt < c_v[i*W +: W];
    return r;
  endfunction

  function automatic exp_t idle_exp(logic o);
    exp_t r;
    r = '0;
    r.ovf = o;
    return r;
  endfunction

  task automatic stop_run();
    en = 0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 0;
    #3;
    sb.push_back(idle_exp(1'b0));
    @(negedge clk);
    got = '{tmr_count, flag, ovf, busy};
    e = sb.pop_front();
    n_chk++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL reset: got %h required %h", got, e);
    end
    rst = 1;
    @(negedge clk);
  endtask

  task automatic run_cont(string name, int ps_v, int p_v, logic [C*W-1:0] c_v, int n);
    ps = PW'(ps_v); per = W'(p_v); cmp = c_v; one_shot = 0;
    en = 1;
    for (int j = 0; j < n; j++) begin
      sb.push_back(model(j, ps_v, p_v, c_v));
      @(negedge clk);
      got = '{tmr_count, flag, ovf, busy};
      e = sb.pop_front();
      n_chk++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s j=%0d: got %h required %h", name, j, got, e);
      end
    end
    stop_run();
  endtask

  task automatic test_continuous();
    run_cont("continuous", 0, 7, {24'd0, 24'd0, 24'd0, 24'd4}, 24);
  endtask

  task automatic test_compare_edges();
    run_cont("compare_edges", 0, 7, {24'd8, 24'd7, 24'd1, 24'd0}, 16);
  endtask

  task automatic test_prescaler();
    run_cont("prescaler", 2, 3, {24'd0, 24'd0, 24'd0, 24'd2}, 30);
  endtask

  task automatic test_shadow();
    logic [C*W-1:0] c_old, c_new;
    c_old = {24'd0, 24'd0, 24'd5, 24'd4};
    c_new = {24'd0, 24'd0, 24'd5, 24'd1};
    ps = 0; per = 7; cmp = c_old; one_shot = 0;
    en = 1;
    for (int j = 0; j < 20; j++) begin
      if (j < 8) sb.push_back(model(j, 0, 7, c_old));
      else begin
        e = model(j - 8, 0, 3, c_new);
        e.ovf = e.ovf | (j == 8);
        sb.push_back(e);
      end
      @(negedge clk);
      got = '{tmr_count, flag, ovf, busy};
      e = sb.pop_front();
      n_chk++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL shadow j=%0d: got %h required %h", j, got, e);
      end
      if (j == 2) begin
        cmp = c_new;
        per = 3;
      end
    end
    stop_run();
  endtask

  task automatic test_one_shot();
    logic [C*W-1:0] c_v;
    c_v = {24'd0, 24'd0, 24'd0, 24'd3};
    ps = 0; per = 5; cmp = c_v; one_shot = 1;
    for (int pass = 0; pass < 2; pass++) begin
      en = 1;
      for (int j = 0; j < 11; j++) begin
        sb.push_back(j < 6 ? model(j, 0, 5, c_v) : idle_exp(j == 6));
        @(negedge clk);
        got = '{tmr_count, flag, ovf, busy};
        e = sb.pop_front();
        n_chk++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL one_shot pass=%0d j=%0d: got %h required %h", pass, j, got, e);
        end
      end
      en = 0;
      @(negedge clk);
    end
    one_shot = 0;
    @(negedge clk);
  endtask

  task automatic test_disable();
    logic [C*W-1:0] c_v;
    c_v = {24'd8, 24'd7, 24'd1, 24'd4};
    ps = 0; per = 7; cmp = c_v; one_shot = 0;
    en = 1;
    for (int j = 0; j < 7; j++) begin
      sb.push_back(j < 6 ? model(j, 0, 7, c_v) : idle_exp(1'b0));
      @(negedge clk);
      got = '{tmr_count, flag, ovf, busy};
      e = sb.pop_front();
      n_chk++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL disable j=%0d: got %h required %h", j, got, e);
      end
      if (j == 5) en = 0;
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    logic [C*W-1:0] c_v;
    c_v = {24'd8, 24'd7, 24'd1, 24'd4};
    ps = 0; per = 7; cmp = c_v; one_shot = 0;
    en = 1;
    for (int j = 0; j < 4; j++) begin
      sb.push_back(model(j, 0, 7, c_v));
      @(negedge clk);
      got = '{tmr_count, flag, ovf, busy};
      e = sb.pop_front();
      n_chk++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL async_pre j=%0d: got %h required %h", j, got, e);
      end
    end
    sb.push_back(idle_exp(1'b0));
    #2 rst = 0;
    #1;
    got = '{tmr_count, flag, ovf, busy};
    e = sb.pop_front();
    n_chk++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL async_reset: got %h required %h", got, e);
    end
    en = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_compare_edges();
    test_shadow();
    test_prescaler();
    test_one_shot();
    test_disable();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pwm_timer_multi.md
Name: pwm_timer_multi

Overview:
Parametrised multi-channel successor to the single-compare 24-bit timer. It has one shared up-counter with a clock prescaler, N independent compare channels that each drive a PWM-style flag, and continuous or one-shot mode. Period, prescale and compare values pass through shadow registers, so software updates take effect glitch-free at the period boundary. The block sits beside the display and LED drivers as a general brightness, PWM and tick source.

Parameters:
- WIDTH, 24: counter, period and compare width.
- CHANNELS, 4: number of compare channels/flags.
- PS_WIDTH, 8: prescaler width.

Ports:
- clk  in  1: system clock; all logic on the rising edge.
- rst  in  1: asynchronous, active-low reset.
- en  in  1: run enable (level).
- one_shot  in  1: 0 = continuous, 1 = one-shot; sampled on the IDLE->RUN transition.
- tmr_prescale  in  PS_WIDTH: count advances once every tmr_prescale+1 clocks.
- tmr_period  in  WIDTH: terminal count; count runs 0..tmr_period.
- tmr_compare  in  CHANNELS*WIDTH: channel i compare value in bits [i*WIDTH +: WIDTH].
- tmr_count  out  WIDTH: current count, registered.
- flag  out  CHANNELS: per-channel compare output, registered.
- ovf  out  1: one-clock pulse on each wrap or terminal event.
- busy  out  1: high in RUN.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; tmr_count=0; prescaler=0; flag=0; ovf=0; busy=0; all shadows=0.
- State machine:
  - IDLE -> RUN when en=1. On that edge, load all shadows: period, prescale, compare[], mode.
  - RUN -> IDLE when en=0. Takes effect on the next edge and has priority over every other event.
  - RUN -> DONE at the terminal event when the mode shadow is one-shot.
  - DONE -> IDLE when en=0. DONE never restarts while en stays high; a restart needs en to drop and rise again.
- Prescaler in RUN:
  - ps_cnt counts 0..ps_shadow.
  - tick=1 when ps_cnt==ps_shadow, then ps_cnt returns to 0.
  - ps_shadow=0 gives a tick every clock.
- Counter on tick:
  - If tmr_count==period_shadow (terminal event): tmr_count<=0, ovf<=1 for exactly one clock, and all shadows reload from the inputs on the same edge.
  - Otherwise tmr_count<=tmr_count+1.
  - Period 0: count stays 0 and ovf pulses on every tick.
- Flags: in RUN, on every edge flag[i] <= (next tmr_count < next compare shadow[i]), so flag always matches the registered count with no extra latency.
  - compare=0: flag stays low.
  - compare>period: flag stays high.
  - compare==period: flag is low only while count==period.
- In IDLE and DONE: tmr_count=0 and flag=0. busy=0 in IDLE and DONE, busy=1 in RUN.
- One-shot: terminal event pulses ovf, enters DONE, and leaves tmr_count=0.
- Input changes during RUN do not affect the current period. They are seen only after the next terminal event or after an IDLE->RUN restart.
- Latency: the first increment occurs ps_shadow+1 clocks after the IDLE->RUN edge.
- Comparisons are unsigned and WIDTH-bit; the count never exceeds the period shadow, so there is no wrap-around beyond the period.

Decomposition:
- Shared package/include: state encodings (IDLE, RUN, DONE) and localparams for default widths.
- One natural sub-module, pwm_compare_ch, instantiated CHANNELS times via generate. Each holds its compare shadow and flag register; load-enable and next-count are inputs.
- The prescaler stays inline.

Test Plan:
- Continuous, basic: WIDTH=24, prescale=0, period=7, compare0=4, en=1 -> count 0..7 repeating; flag0 high for counts 0-3 and low for 4-7; ovf one clock per 8 clocks, coincident with count=0.
- Compare edge values, with channels 0..3 set to 0, 1, 7, 8 and period=7:
  - ch0 always low;
  - ch1 high only at count 0;
  - ch2 low only at count 7;
  - ch3 always high.
- Shadow update: change compare0 from 4 to 1 at count=2 -> flag0 keeps the 4-duty pattern until the wrap, then shows the 1-duty pattern from count 0. Repeat with the period changed 7->3 mid-period -> the new period applies after the wrap.
- Prescaler: prescale=2, period=3 -> count advances every 3 clocks; wrap/ovf every 12 clocks; the first increment is 3 clocks after en rises.
- One-shot: one_shot=1, period=5 -> one pass 0..5, a single ovf pulse, busy falls, count held at 0 with en still high. Dropping and raising en runs exactly one more pass.
- Reset and disable mid-run: assert rst low asynchronously at count=3 -> all outputs 0 immediately, without waiting for a clock edge. Separately, drop en at count=5 -> IDLE on the next edge with count=0 and flags=0.
